// File: rtl/icache_rd.sv
// icache_rd: direct-mapped read-only instruction cache, 4-word blocks, zero-latency hits; `ICACHE_PERF_CNT_EN adds hit/miss counters.
module icache_rd #(
  parameter int NUM_BLOCKS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);
  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = 28 - IDX_W;
  typedef enum logic {IDLE, ALLOC} state_t;
  state_t state, next_state;
  logic [NUM_BLOCKS-1:0] valid;
  logic [TAG_W-1:0] tags [NUM_BLOCKS];
  logic [127:0] lines [NUM_BLOCKS];
  logic [27:0] miss_addr;
  logic [IDX_W-1:0] idx, fill_idx;
  logic hit, fill, unused;
  assign idx = proc_addr[IDX_W+1:2];
  assign fill_idx = miss_addr[IDX_W-1:0];
  assign hit = proc_read && valid[idx] && tags[idx] == proc_addr[29:IDX_W+2];
  assign fill = state == ALLOC && mem_ready;
  assign proc_rdata = lines[idx][{proc_addr[1:0], 5'd0} +: 32];
  assign mem_read = state == ALLOC;
  assign mem_write = 1'b0;
  assign mem_addr = miss_addr;
  assign unused = ^{proc_write, proc_wdata};
  always_comb begin
    proc_stall = state == ALLOC || (proc_read && !hit);
    next_state = state == IDLE ? (proc_stall ? ALLOC : IDLE) : (mem_ready ? IDLE : ALLOC);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && proc_stall) miss_addr <= proc_addr[29:2];
      if (fill) valid[fill_idx] <= 1'b1;
    end
  end
  // line payload needs no reset: valid bits alone gate its use
  always_ff @(posedge clk) begin
    if (fill) begin
      lines[fill_idx] <= mem_rdata;
      tags[fill_idx]  <= miss_addr[27:IDX_W];
    end
  end
`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (state == IDLE && hit) hit_cnt <= hit_cnt + 32'd1;
      if (state == IDLE && proc_stall) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_rd.sv
// tb_icache_rd: randomized bench for icache_rd against a block-address reference model.
module tb_icache_rd;
  localparam int NB = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic proc_read = 1'b0, proc_write = 1'b0, proc_stall, mem_read, mem_write, mem_ready = 1'b0;
  logic [29:0] proc_addr = '0;
  logic [31:0] proc_wdata = '0, proc_rdata;
  logic [27:0] mem_addr;
  logic [127:0] mem_rdata = '0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  int errors = 0, checks = 0, m_hits = 0, m_misses = 0;
  logic m_valid [NB];
  logic [27:0] m_blk [NB];
  logic [127:0] backing [logic [27:0]];

  always #5 clk = ~clk;

  icache_rd #(.NUM_BLOCKS(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .proc_stall(proc_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef ICACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] blk_data(input logic [27:0] b);
    if (!backing.exists(b)) backing[b] = {$urandom, $urandom, $urandom, $urandom};
    return backing[b];
  endfunction

  task automatic chk_perf();
`ifdef ICACHE_PERF_CNT_EN
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);
`endif
  endtask

  task automatic clear_model();
    for (int i = 0; i < NB; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; proc_read = 1'b0; proc_write = 1'b0; mem_ready = 1'b0;
    #1;
    clear_model();
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_addr", mem_addr, 28'h0);
    check("rst_stall", proc_stall, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    chk_perf();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input logic w, input logic r);
    @(negedge clk);
    proc_read = 1'b0; proc_write = w; mem_ready = r;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check("idle_stall", proc_stall, 1'b0);
    check("idle_mem_read", mem_read, 1'b0);
    chk_perf();
  endtask

  // One fetch; on a miss the bench plays memory and answers after n wait cycles.
  task automatic rd(input logic [29:0] a, input int n, input logic w);
    logic [27:0] b;
    logic [127:0] d;
    int ix, k, st;
    b = a[29:2];
    ix = int'(b[2:0]);
    k = int'(a[1:0]);
    d = blk_data(b);
    @(negedge clk);
    proc_read = 1'b1; proc_write = w; proc_addr = a; mem_ready = 1'b0;
    #1;
    if (m_valid[ix] && m_blk[ix] == b) begin
      check("hit_stall", proc_stall, 1'b0);
      check("hit_data", proc_rdata, d[k*32 +: 32]);
      check("hit_mem_read", mem_read, 1'b0);
      m_hits++;
    end else begin
      st = int'(proc_stall);
      check("miss_stall", proc_stall, 1'b1);
      check("miss_detect_mem_read", mem_read, 1'b0);
      m_misses++;
      for (int c = 0; c <= n; c++) begin
        @(negedge clk);
        proc_write = 1'($urandom_range(0, 1));
        mem_ready = (c == n);
        mem_rdata = (c == n) ? d : {$urandom, $urandom, $urandom, $urandom};
        #1;
        st += int'(proc_stall);
        check("fill_mem_read", mem_read, 1'b1);
        check("fill_mem_addr", mem_addr, b);
      end
      @(negedge clk);
      mem_ready = 1'b0; proc_write = w;
      #1;
      m_valid[ix] = 1'b1;
      m_blk[ix] = b;
      st += int'(proc_stall);
      check("stall_cycles", st, n + 2);
      check("replay_stall", proc_stall, 1'b0);
      check("replay_data", proc_rdata, d[k*32 +: 32]);
      check("replay_mem_read", mem_read, 1'b0);
      m_hits++;
    end
  endtask

  // Reset lands two cycles into the fill; the late mem_ready must not install the line.
  task automatic rst_mid(input logic [29:0] a);
    @(negedge clk);
    proc_read = 1'b1; proc_write = 1'b0; proc_addr = a; mem_ready = 1'b0;
    #1;
    check("rm_stall", proc_stall, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check("rm_mem_read_pre", mem_read, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_async_mem_read", mem_read, 1'b0);
    clear_model();
    @(negedge clk);
    proc_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1; mem_rdata = blk_data(a[29:2]);
    #1;
    check("rm_ready_ignored", mem_read, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    rd(a, 1, 1'b0);
  endtask

  initial begin
    logic [24:0] tg [4];
    for (int i = 0; i < 4; i++) tg[i] = 25'($urandom);
    tg[0] = '0;
    do_reset();
    backing[28'h4] = 128'h44443333_22221111_00000013_AAAABBBB;
    rd(30'h10, 0, 1'b0);
    rd(30'h11, 0, 1'b0);
    rd(30'h12, 0, 1'b0);
    rd(30'h13, 0, 1'b1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    rd(30'h30, 1, 1'b0);
    rd(30'h10, 2, 1'b0);
    rd(30'h50, 7, 1'b0);
    rd(30'h51, 0, 1'b0);
    do_reset();
    rst_mid(30'h10);
    idle(1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0)
        idle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        rd({tg[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))},
           $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    idle(1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
